rle_run_expander: RTL and testbench

Parametrised run-length expander for one colour plane of the RLE image decoder. Accepts (count, value) run tokens over a valid/ready handshake and emits the decoded pixel stream with backpressure, a new-row strobe and a sticky frame-done flag. Generalises the fixed 8-bit per-channel decode path to any pixel width, run-count width and frame geometry. Also detects runs that overflow the frame. The top level instantiates one per channel (R, G, B).

---
 rtl/rle_run_expander.sv | 115 +++++++++++
 tb/tb_rle_run_expander.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rle_run_expander.sv
// Run-length expander for one colour plane: turns (count, value) tokens into a
// pixel stream with row-end marking, frame-done and run-overflow detection.
module rle_run_expander #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned HEIGHT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CNT_W-1:0]  in_count,
    input  logic [DATA_W-1:0] in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_nr,
    output logic              done,
    output logic              err
);

    localparam int unsigned COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [CNT_W-1:0]   r_run_left;

    logic               w_beat;
    logic               w_col_last;
    logic               w_frame_last;
    logic [COL_W-1:0]   w_col_next;
    logic [ROW_W-1:0]   w_row_next;

    // r_col/r_row always name the position of the pixel currently presented
    assign w_beat       = (r_state == S_RUN) && out_ready;
    assign w_col_last   = (r_col == COL_LAST);
    assign w_frame_last = w_col_last && (r_row == ROW_LAST);
    assign w_col_next   = w_col_last ? '0 : COL_W'(r_col + 1'b1);
    assign w_row_next   = w_col_last ? ROW_W'(r_row + 1'b1) : r_row;
    assign in_ready     = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_run_left <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_nr     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else if (start) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_run_left <= '0;
            out_valid  <= 1'b0;
            out_nr     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Empty runs are consumed here without leaving IDLE
                    if (in_valid && (in_count != '0)) begin
                        out_data   <= in_value;
                        r_run_left <= in_count;
                        out_valid  <= 1'b1;
                        out_nr     <= w_col_last;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_beat) begin
                        if (w_frame_last) begin
                            r_state    <= S_DONE;
                            out_valid  <= 1'b0;
                            out_nr     <= 1'b0;
                            done       <= 1'b1;
                            err        <= (r_run_left > CNT_W'(1));
                            r_run_left <= '0;
                        end else begin
                            r_col      <= w_col_next;
                            r_row      <= w_row_next;
                            r_run_left <= CNT_W'(r_run_left - 1'b1);
                            if (r_run_left == CNT_W'(1)) begin
                                r_state   <= S_IDLE;
                                out_valid <= 1'b0;
                                out_nr    <= 1'b0;
                            end else begin
                                out_nr    <= (w_col_next == COL_LAST);
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rle_run_expander.sv
// Directed bench for rle_run_expander on a 4x2 frame with hand-computed streams.
module tb_rle_run_expander;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_count = '0;
    logic [7:0] in_value = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_nr;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_d  [16];
    logic       got_nr [16];
    int         got_n;
    logic [7:0] exp_d  [16];
    logic       exp_nr [16];

    rle_run_expander #(
        .DATA_W(8), .CNT_W(8), .WIDTH(4), .HEIGHT(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_count(in_count), .in_value(in_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_nr(out_nr),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one token until accepted; returns #1 after the accepting edge
    task automatic send_token(input logic [7:0] cnt, input logic [7:0] val);
        int k = 0;
        in_valid = 1'b1;
        in_count = cnt;
        in_value = val;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        check("tok_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Collect pixels until got_n reaches total; toggle selects ready pattern 1,0,0,...
    task automatic collect(input int total, input bit toggle);
        int         i = 0;
        bit         stall = 1'b0;
        logic [7:0] hd = '0;
        logic       hn = 1'b0;
        while (got_n < total && i < 200) begin
            out_ready = toggle ? (i % 3 == 0) : 1'b1;
            if (stall) begin
                check("stall_data", 32'(out_data), 32'(hd));
                check("stall_nr", 32'(out_nr), 32'(hn));
            end
            stall = out_valid && !out_ready;
            hd    = out_data;
            hn    = out_nr;
            if (out_valid && out_ready) begin
                got_d[got_n]  = out_data;
                got_nr[got_n] = out_nr;
                got_n++;
            end
            step();
            i++;
        end
        out_ready = 1'b1;
        check("px_count", 32'(got_n), 32'(total));
    endtask

    task automatic verify_stream(input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("px%0d_data", i), 32'(got_d[i]), 32'(exp_d[i]));
            check($sformatf("px%0d_nr", i), 32'(got_nr[i]), 32'(exp_nr[i]));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            got_d[i] = '0; got_nr[i] = 1'b0; exp_d[i] = '0; exp_nr[i] = 1'b0;
        end
        got_n = 0;

        // Reset values
        step(); step();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_nr", 32'(out_nr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Frame (3,10),(5,20) with out_ready held high
        for (int i = 0; i < 8; i++) begin
            exp_d[i]  = (i < 3) ? 8'd10 : 8'd20;
            exp_nr[i] = (i == 3) || (i == 7);
        end
        got_n = 0;
        send_token(8'd3, 8'd10);
        check("t1_first_valid", 32'(out_valid), 32'd1);
        collect(3, 1'b0);
        check("t1_ready_after_run", 32'(in_ready), 32'd1);
        check("t1_valid_bubble", 32'(out_valid), 32'd0);
        send_token(8'd5, 8'd20);
        collect(8, 1'b0);
        verify_stream(8);
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_in_ready_done", 32'(in_ready), 32'd0);
        check("t1_valid_done", 32'(out_valid), 32'd0);

        // Re-arm and repeat with stalls
        pulse_start();
        check("t2_done_clr", 32'(done), 32'd0);
        check("t2_in_ready", 32'(in_ready), 32'd1);
        got_n = 0;
        send_token(8'd3, 8'd10);
        collect(3, 1'b1);
        send_token(8'd5, 8'd20);
        collect(8, 1'b1);
        verify_stream(8);
        check("t2_done", 32'(done), 32'd1);
        check("t2_err", 32'(err), 32'd0);

        // Empty run is swallowed
        pulse_start();
        send_token(8'd0, 8'd99);
        check("t3_empty_no_valid", 32'(out_valid), 32'd0);
        check("t3_empty_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            exp_d[i]  = 8'd7;
            exp_nr[i] = (i == 3) || (i == 7);
        end
        got_n = 0;
        send_token(8'd8, 8'd7);
        collect(8, 1'b0);
        verify_stream(8);
        check("t3_done", 32'(done), 32'd1);
        check("t3_err", 32'(err), 32'd0);

        // Run overflowing the frame
        pulse_start();
        for (int i = 0; i < 8; i++) exp_d[i] = 8'd5;
        got_n = 0;
        send_token(8'd10, 8'd5);
        collect(8, 1'b0);
        verify_stream(8);
        check("t4_done", 32'(done), 32'd1);
        check("t4_err", 32'(err), 32'd1);
        step(); step(); step();
        check("t4_in_ready_hold", 32'(in_ready), 32'd0);
        check("t4_valid_hold", 32'(out_valid), 32'd0);
        check("t4_err_hold", 32'(err), 32'd1);

        // Abort mid-run, then a fresh full frame
        pulse_start();
        check("t5_err_clr", 32'(err), 32'd0);
        got_n = 0;
        send_token(8'd6, 8'd3);
        collect(2, 1'b0);
        check("t5_valid_before_abort", 32'(out_valid), 32'd1);
        pulse_start();
        check("t5_valid_after_abort", 32'(out_valid), 32'd0);
        check("t5_ready_after_abort", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) exp_d[i] = 8'd1;
        got_n = 0;
        send_token(8'd8, 8'd1);
        collect(8, 1'b0);
        verify_stream(8);
        check("t5_done", 32'(done), 32'd1);
        check("t5_err", 32'(err), 32'd0);

        // Reset from DONE
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_out_data", 32'(out_data), 32'd0);
        check("t6_out_nr", 32'(out_nr), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
